// File: rtl/chess_pkg.sv
// chess_pkg: bitboard layout constants, board masks and checker FSM states.
package chess_pkg;
  localparam int BLACK_BASE = 0;
  localparam int WHITE_BASE = 6;
  localparam int PAWN       = 0;
  localparam int KNIGHT     = 1;
  localparam int BISHOP     = 2;
  localparam int ROOK       = 3;
  localparam int QUEEN      = 4;
  localparam int KING       = 5;

  localparam logic [63:0] NOT_A_FILE = 64'hfefefefefefefefe;
  localparam logic [63:0] NOT_H_FILE = 64'h7f7f7f7f7f7f7f7f;
  localparam logic [63:0] RANK1      = 64'h00000000000000ff;
  localparam logic [63:0] RANK8      = 64'hff00000000000000;

  typedef enum logic [2:0] {ST_IDLE, ST_APPLY, ST_ATTACK, ST_CHECK, ST_DONE} state_e;

  // Piece type a promoting pawn becomes; 0 and codes 5-7 fall back to queen
  function automatic logic [2:0] promo_type(input logic [2:0] promo);
    case (promo)
      3'd1:    promo_type = 3'(KNIGHT);
      3'd2:    promo_type = 3'(BISHOP);
      3'd3:    promo_type = 3'(ROOK);
      default: promo_type = 3'(QUEEN);
    endcase
  endfunction
endpackage

// File: rtl/Complete_Attack_Set.sv
// Complete_Attack_Set: every square attacked by the side selected by is_white.
module Complete_Attack_Set
  import chess_pkg::*;
(
  input  logic [767:0] board,
  input  logic         is_white,
  output logic [63:0]  attack
);
  logic [63:0] occ;
  logic [63:0] pc [6];
  int          r, f, nr, nf;
  logic        blk;

  for (genvar gi = 0; gi < 6; gi++) begin : g_side
    assign pc[gi] = is_white ? board[(WHITE_BASE + gi) * 64 +: 64]
                             : board[(BLACK_BASE + gi) * 64 +: 64];
  end

  // Occupancy of both colours blocks sliding pieces
  always_comb begin
    occ = '0;
    for (int k = 0; k < 12; k++) occ = occ | board[k * 64 +: 64];
  end

  // Pawn captures by shifting; knights, kings and rays walked square by square
  always_comb begin
    r = 0; f = 0; nr = 0; nf = 0; blk = 1'b0;
    attack = is_white ? (((pc[PAWN] << 7) & NOT_H_FILE) | ((pc[PAWN] << 9) & NOT_A_FILE))
                      : (((pc[PAWN] >> 9) & NOT_H_FILE) | ((pc[PAWN] >> 7) & NOT_A_FILE));
    for (int sq = 0; sq < 64; sq++) begin
      r = sq / 8;
      f = sq % 8;
      for (int dr = -2; dr <= 2; dr++) begin
        for (int df = -2; df <= 2; df++) begin
          nr = r + dr;
          nf = f + df;
          if (nr >= 0 && nr < 8 && nf >= 0 && nf < 8) begin
            if (((dr * dr + df * df) == 5 && pc[KNIGHT][6'(sq)]) ||
                (((dr * dr + df * df) == 1 || (dr * dr + df * df) == 2) && pc[KING][6'(sq)]))
              attack[6'(nr * 8 + nf)] = 1'b1;
          end
        end
      end
      for (int dr = -1; dr <= 1; dr++) begin
        for (int df = -1; df <= 1; df++) begin
          if ((dr != 0 || df != 0) &&
              (((dr != 0 && df != 0) ? pc[BISHOP][6'(sq)] : pc[ROOK][6'(sq)]) || pc[QUEEN][6'(sq)])) begin
            blk = 1'b0;
            for (int d = 1; d < 8; d++) begin
              nr = r + dr * d;
              nf = f + df * d;
              if (!blk && nr >= 0 && nr < 8 && nf >= 0 && nf < 8) begin
                attack[6'(nr * 8 + nf)] = 1'b1;
                blk = occ[6'(nr * 8 + nf)];
              end
            end
          end
        end
      end
    end
  end
endmodule

// File: rtl/move_apply.sv
// move_apply: combinational trial-board builder for one candidate move.
module move_apply
  import chess_pkg::*;
(
  input  logic [5:0]   from_sq,
  input  logic [5:0]   to_sq,
  input  logic         side_white,
  input  logic [2:0]   promo,
  input  logic [767:0] board,
  output logic [767:0] trial,
  output logic         err,
  output logic         capture
);
  logic [63:0] slice [12];
  logic [11:0] from_hit, to_hit, own_mask;
  logic [5:0]  own_from, own_to;
  logic [2:0]  move_type, dest_type;
  logic        found, promote;
  logic [63:0] s_work;

  for (genvar gi = 0; gi < 12; gi++) begin : g_slice
    assign slice[gi]    = board[gi * 64 +: 64];
    assign from_hit[gi] = slice[gi][from_sq];
    assign to_hit[gi]   = slice[gi][to_sq];
    assign own_mask[gi] = ((gi >= WHITE_BASE) == side_white);
  end

  assign own_from = side_white ? from_hit[11:6] : from_hit[5:0];
  assign own_to   = side_white ? to_hit[11:6]   : to_hit[5:0];

  // Lowest own slice holding the source square names the moving piece
  always_comb begin
    move_type = 3'd0;
    found     = 1'b0;
    for (int p = 5; p >= 0; p--) begin
      if (own_from[p]) begin
        move_type = 3'(p);
        found     = 1'b1;
      end
    end
  end

  assign promote   = (move_type == 3'(PAWN)) && (side_white ? RANK8[to_sq] : RANK1[to_sq]);
  assign dest_type = promote ? promo_type(promo) : move_type;
  assign err       = ~found | (|own_to) | (from_sq == to_sq);

  // Lift the mover off its square, remove any captured piece, drop the mover on the target
  always_comb begin
    trial   = '0;
    capture = 1'b0;
    s_work  = '0;
    for (int k = 0; k < 12; k++) begin
      s_work = slice[k];
      if (own_mask[k]) begin
        s_work[from_sq] = 1'b0;
        if (found && (k == (side_white ? WHITE_BASE : BLACK_BASE) + int'(dest_type)))
          s_work[to_sq] = 1'b1;
      end else begin
        capture       = capture | s_work[to_sq];
        s_work[to_sq] = 1'b0;
      end
      trial[k * 64 +: 64] = s_work;
    end
  end
endmodule

// File: rtl/move_legality_checker.sv
// move_legality_checker: applies one move, tests the mover's king against the
// opponent's attack set and hands back verdict plus trial board.
module move_legality_checker
  import chess_pkg::*;
#(
  parameter int ATTACK_PIPE = 1
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         move_valid,
  output logic         move_ready,
  input  logic [5:0]   move_from,
  input  logic [5:0]   move_to,
  input  logic         side_white,
  input  logic [2:0]   promo_piece,
  input  logic [767:0] board_in,
  output logic         result_valid,
  input  logic         result_ready,
  output logic         result_legal,
  output logic         result_err,
  output logic         result_capture,
  output logic [767:0] result_board
);
  state_e       state_q, state_d;
  logic [5:0]   from_q, from_d, to_q, to_d;
  logic         side_q, side_d;
  logic [2:0]   promo_q, promo_d;
  logic [767:0] board_q, board_d, trial_q, trial_d, res_board_q, res_board_d;
  logic         err_q, err_d, cap_q, cap_d;
  logic [63:0]  attack_q, attack_d;
  logic         legal_q, legal_d, res_err_q, res_err_d, res_cap_q, res_cap_d;
  logic [767:0] trial_c;
  logic         err_c, cap_c;
  logic [63:0]  attack_c, attack_use, king_bb;

  move_apply u_apply (
    .from_sq(from_q), .to_sq(to_q), .side_white(side_q), .promo(promo_q),
    .board(board_q), .trial(trial_c), .err(err_c), .capture(cap_c)
  );

  Complete_Attack_Set u_attack (
    .board(trial_q), .is_white(~side_q), .attack(attack_c)
  );

  assign attack_use     = (ATTACK_PIPE != 0) ? attack_q : attack_c;
  assign king_bb        = side_q ? trial_q[(WHITE_BASE + KING) * 64 +: 64]
                                 : trial_q[(BLACK_BASE + KING) * 64 +: 64];
  assign move_ready     = (state_q == ST_IDLE);
  assign result_valid   = (state_q == ST_DONE);
  assign result_legal   = legal_q;
  assign result_err     = res_err_q;
  assign result_capture = res_cap_q;
  assign result_board   = res_board_q;

  // Phase sequencing and per-phase datapath captures
  always_comb begin
    state_d     = state_q;
    from_d      = from_q;
    to_d        = to_q;
    side_d      = side_q;
    promo_d     = promo_q;
    board_d     = board_q;
    trial_d     = trial_q;
    err_d       = err_q;
    cap_d       = cap_q;
    attack_d    = attack_q;
    legal_d     = legal_q;
    res_err_d   = res_err_q;
    res_cap_d   = res_cap_q;
    res_board_d = res_board_q;
    case (state_q)
      ST_IDLE: if (move_valid) begin
        from_d  = move_from;
        to_d    = move_to;
        side_d  = side_white;
        promo_d = promo_piece;
        board_d = board_in;
        state_d = ST_APPLY;
      end
      ST_APPLY: begin
        trial_d = trial_c;
        err_d   = err_c;
        cap_d   = cap_c;
        state_d = (ATTACK_PIPE != 0) ? ST_ATTACK : ST_CHECK;
      end
      ST_ATTACK: begin
        attack_d = attack_c;
        state_d  = ST_CHECK;
      end
      ST_CHECK: begin
        // A malformed move is never legal and leaves the board untouched
        legal_d     = ~err_q & ~(|(king_bb & attack_use));
        res_err_d   = err_q;
        res_cap_d   = cap_q;
        res_board_d = err_q ? board_q : trial_q;
        state_d     = ST_DONE;
      end
      ST_DONE: if (result_ready) state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // State register; reset abandons any move in flight and clears the result
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= ST_IDLE;
      from_q      <= '0;
      to_q        <= '0;
      side_q      <= 1'b0;
      promo_q     <= '0;
      board_q     <= '0;
      trial_q     <= '0;
      err_q       <= 1'b0;
      cap_q       <= 1'b0;
      attack_q    <= '0;
      legal_q     <= 1'b0;
      res_err_q   <= 1'b0;
      res_cap_q   <= 1'b0;
      res_board_q <= '0;
    end else begin
      state_q     <= state_d;
      from_q      <= from_d;
      to_q        <= to_d;
      side_q      <= side_d;
      promo_q     <= promo_d;
      board_q     <= board_d;
      trial_q     <= trial_d;
      err_q       <= err_d;
      cap_q       <= cap_d;
      attack_q    <= attack_d;
      legal_q     <= legal_d;
      res_err_q   <= res_err_d;
      res_cap_q   <= res_cap_d;
      res_board_q <= res_board_d;
    end
  end
endmodule
